// File: rtl/fp2int_pkg.sv
// Shared types and constants for the FP32-to-INT32 conversion scheduler.
package fp2int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] FP32_BIAS   = 8'd127;
    localparam logic [7:0] INT_EXP_MAX = 8'd158;
    localparam int         FRAC_W      = 23;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/fp2int_core.sv
// Combinational FP32 -> INT32 conversion, truncating toward zero.
// Build with FP2INT_SAT_EN for saturating overflow handling and an ovf flag.
module fp2int_core
    import fp2int_pkg::*;
(
    input  logic [31:0] fp,
    output logic [31:0] res
`ifdef FP2INT_SAT_EN
    ,
    output logic        ovf
`endif
);

    // Exponent at which the 24-bit mantissa is already an integer.
    localparam logic [7:0] EXP_INT = FP32_BIAS + 8'(FRAC_W);

    logic              sign;
    logic [7:0]        expo;
    logic [FRAC_W-1:0] frac;
    logic [31:0]       mag;
    logic              over;

    assign sign = fp[31];
    assign expo = fp[30:23];
    assign frac = fp[FRAC_W-1:0];

    always_comb begin
        mag  = '0;
        over = 1'b0;
        if (expo < FP32_BIAS) begin
            mag = '0;
        end else if (expo <= EXP_INT) begin
            mag = {8'd0, 1'b1, frac} >> (EXP_INT - expo);
        end else if (expo < INT_EXP_MAX) begin
            mag = {8'd0, 1'b1, frac} << (expo - EXP_INT);
        end else if (sign && (expo == INT_EXP_MAX) && (frac == '0)) begin
            // -2^31 is representable even though its magnitude is not.
            mag = SAT_NEG;
        end else begin
            over = 1'b1;
        end
    end

`ifdef FP2INT_SAT_EN
    assign ovf = over;

    always_comb begin
        res = sign ? -mag : mag;
        if (over) begin
            if ((expo == 8'hFF) && (frac != '0))
                res = '0;
            else
                res = sign ? SAT_NEG : SAT_POS;
        end
    end
`else
    always_comb begin
        res = sign ? -mag : mag;
        if (over)
            res = SAT_NEG;
    end
`endif

endmodule

// File: rtl/fp2int_sched.sv
// Round-robin scheduler sharing one FP32->INT32 converter among NREQ requesters.
// Optional FP2INT_SAT_EN adds saturation and the out_ovf port.
module fp2int_sched
    import fp2int_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*32-1:0] req_fp,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_int,
    output logic [IDW-1:0]    out_id,
    output logic              busy
`ifdef FP2INT_SAT_EN
    ,
    output logic              out_ovf
`endif
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends on ready, and out_valid/out_int/out_id hold
    // until the transfer completes.

    state_t          state, state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_q;
    logic [31:0]     op_q;
    logic [31:0]     core_int;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic            accept;

`ifdef FP2INT_SAT_EN
    logic core_ovf;

    fp2int_core u_core (
        .fp  (op_q),
        .res (core_int),
        .ovf (core_ovf)
    );
`else
    fp2int_core u_core (
        .fp  (op_q),
        .res (core_int)
    );
`endif

    // Walk downward so the last hit is the nearest set bit at/after rr_ptr.
    always_comb begin
        int c;
        c         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= NREQ)
                c = c - NREQ;
            if (req_valid[c]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(c);
            end
        end
    end

    assign accept    = grant_any && ((state == IDLE) || ((state == DONE) && out_ready));
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CONV;
            CONV: state_next = DONE;
            DONE: if (out_ready) state_next = accept ? CONV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            op_q    <= '0;
            out_int <= '0;
            out_id  <= '0;
`ifdef FP2INT_SAT_EN
            out_ovf <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q   <= req_fp[int'(grant_idx)*32 +: 32];
                id_q   <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == CONV) begin
                out_int <= core_int;
                out_id  <= id_q;
`ifdef FP2INT_SAT_EN
                out_ovf <= core_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp2int_sched.sv
// Directed self-checking bench for fp2int_sched (default and FP2INT_SAT_EN builds).
module tb_fp2int_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_fp;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_int;
    logic [IDW-1:0]     out_id;
    logic               busy;
`ifdef FP2INT_SAT_EN
    logic               out_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fp2int_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_fp    (req_fp),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_id    (out_id),
        .busy      (busy)
`ifdef FP2INT_SAT_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single isolated conversion on requester id; inputs change on negedges.
    task automatic convert(input string tag, input int id, input logic [31:0] fp,
                           input logic [31:0] exp_int, input logic exp_ovf);
        @(negedge clk);
        req_valid          = '0;
        req_valid[id]      = 1'b1;
        req_fp[id*32 +: 32] = fp;
        out_ready          = 1'b0;
        #1 check({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        check({tag, ".conv_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".conv_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".int"}, out_int, exp_int);
        check({tag, ".id"}, 32'(out_id), 32'(id));
`ifdef FP2INT_SAT_EN
        check({tag, ".ovf"}, 32'(out_ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    localparam logic [31:0] OVF_POS =
`ifdef FP2INT_SAT_EN
        32'h7FFF_FFFF;
`else
        32'h8000_0000;
`endif
    localparam logic [31:0] OVF_NAN =
`ifdef FP2INT_SAT_EN
        32'h0000_0000;
`else
        32'h8000_0000;
`endif

    initial begin
        logic [31:0] held_int;
        rst_n     = 1'b0;
        req_valid = '0;
        req_fp    = '0;
        out_ready = 1'b0;
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.int", out_int, 32'd0);
        check("rst.id", 32'(out_id), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        convert("one",     0, 32'h3F80_0000, 32'h0000_0001, 1'b0);
        convert("m2p5",    1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0);
        convert("below1",  2, 32'h3F7F_FFFF, 32'h0000_0000, 1'b0);
        convert("e150",    3, 32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0);
        convert("exact23", 0, 32'h4B00_0000, 32'h0080_0000, 1'b0);
        convert("e157",    1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0);
        convert("m123",    2, 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0);
        convert("zero",    3, 32'h0000_0000, 32'h0000_0000, 1'b0);
        convert("denorm",  0, 32'h0000_0001, 32'h0000_0000, 1'b0);
        convert("povf",    1, 32'h4F00_0000, OVF_POS,       1'b1);
        convert("intmin",  2, 32'hCF00_0000, 32'h8000_0000, 1'b0);
        convert("pinf",    3, 32'h7F80_0000, OVF_POS,       1'b1);
        convert("ninf",    0, 32'hFF80_0000, 32'h8000_0000, 1'b1);
        convert("nan",     1, 32'h7FC0_0000, OVF_NAN,       1'b1);

        // Backpressure: requester 2 result held while requester 1 waits.
        @(negedge clk);
        req_valid      = 4'b0100;
        req_fp[95:64]  = 32'h4120_0000;   // 10.0
        req_fp[63:32]  = 32'h40E0_0000;   // 7.0
        #1 check("bp.ready2", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b0010;
        check("bp.conv_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        held_int = out_int;
        check("bp.int", held_int, 32'd10);
        for (int i = 0; i < 5; i++) begin
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_int", out_int, 32'd10);
            check("bp.hold_id", 32'(out_id), 32'd2);
            check("bp.hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp.b2b_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        out_ready = 1'b0;
        check("bp.conv2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp.int2", out_int, 32'd7);
        check("bp.id2", 32'(out_id), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during CONV, with rr_ptr advanced to 3 beforehand.
        req_valid     = 4'b0100;
        req_fp[95:64] = 32'h4140_0000;    // 12.0
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check("rst2.in_conv", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst2.busy", 32'(busy), 32'd0);
        check("rst2.valid", 32'(out_valid), 32'd0);
        check("rst2.int", out_int, 32'd0);
        @(negedge clk);
        check("rst2.no_result", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Round robin with all requesters active; values are 1.0..4.0.
        @(negedge clk);
        req_fp    = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1 check("rr.grant0", 32'(req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr.conv_ready", 32'(req_ready), 32'd0);
            check("rr.conv_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            #1;
            check("rr.valid", 32'(out_valid), 32'd1);
            check("rr.id", 32'(out_id), 32'(k % 4));
            check("rr.int", out_int, 32'((k % 4) + 1));
            check("rr.next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
            if (k == 4)
                req_valid = '0;
        end
        @(negedge clk);
        check("rr.end_idle", 32'(busy), 32'd0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
